// File: rtl/angle_feedback_decoder.sv
// Two-axis quadrature feedback decoder: sync, stability filter, x4 decode, clamped counter.
// Optional QUAD_ERR_DETECT_EN adds sticky illegal-transition flags and a saturating error count.
module afd_axis #(
    parameter int          FILT_LEN = 4,
    parameter logic [15:0] POS_MIN  = 16'd0,
    parameter logic [15:0] POS_MAX  = 16'hFFFF,
    parameter logic [15:0] HOME_VAL = 16'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        home,
    input  logic        a,
    input  logic        b,
    output logic [15:0] pos,
    output logic        step,
    output logic        dir,
    output logic        at_lim
`ifdef QUAD_ERR_DETECT_EN
    ,
    output logic        illegal
`endif
);
    localparam int CW = $clog2(FILT_LEN + 1);

    logic [1:0]    sync1_q, sync1_d, sync2_q, sync2_d, cand_q, cand_d;
    logic [1:0]    filt_q, filt_d, prev_q, prev_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          filt_vld_q, filt_vld_d, prev_vld_q, prev_vld_d;
    logic [15:0]   pos_q, pos_d;
    logic          step_q, step_d, dir_q, dir_d, lim_q, lim_d;

    always_comb begin
        sync1_d    = {a, b};
        sync2_d    = sync1_q;
        cand_d     = sync2_q;
        filt_d     = filt_q;
        filt_vld_d = filt_vld_q;
        if (sync2_q != cand_q)          cnt_d = CW'(1);
        else if (cnt_q == CW'(FILT_LEN)) cnt_d = cnt_q;
        else                             cnt_d = cnt_q + CW'(1);
        if (cnt_d == CW'(FILT_LEN)) begin
            filt_d     = sync2_q;
            filt_vld_d = 1'b1;
        end
        // The first filtered state after reset only seeds prev; it never counts.
        prev_d     = filt_q;
        prev_vld_d = filt_vld_q;

        pos_d  = pos_q;
        step_d = 1'b0;
        dir_d  = dir_q;
        if (home) begin
            pos_d = HOME_VAL;
        end else if (en && prev_vld_q) begin
            case ({prev_q, filt_q})
                4'b0010, 4'b1011, 4'b1101, 4'b0100:
                    if (pos_q != POS_MAX) begin
                        pos_d  = pos_q + 16'd1;
                        step_d = 1'b1;
                        dir_d  = 1'b1;
                    end
                4'b0001, 4'b0111, 4'b1110, 4'b1000:
                    if (pos_q != POS_MIN) begin
                        pos_d  = pos_q - 16'd1;
                        step_d = 1'b1;
                        dir_d  = 1'b0;
                    end
                default: ;
            endcase
        end
        lim_d = (pos_d == POS_MIN) | (pos_d == POS_MAX);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q    <= 2'b00;
            sync2_q    <= 2'b00;
            cand_q     <= 2'b00;
            cnt_q      <= '0;
            filt_q     <= 2'b00;
            filt_vld_q <= 1'b0;
            prev_q     <= 2'b00;
            prev_vld_q <= 1'b0;
            pos_q      <= HOME_VAL;
            step_q     <= 1'b0;
            dir_q      <= 1'b0;
            lim_q      <= 1'b0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            cand_q     <= cand_d;
            cnt_q      <= cnt_d;
            filt_q     <= filt_d;
            filt_vld_q <= filt_vld_d;
            prev_q     <= prev_d;
            prev_vld_q <= prev_vld_d;
            pos_q      <= pos_d;
            step_q     <= step_d;
            dir_q      <= dir_d;
            lim_q      <= lim_d;
        end
    end

    assign pos    = pos_q;
    assign step   = step_q;
    assign dir    = dir_q;
    assign at_lim = lim_q;
`ifdef QUAD_ERR_DETECT_EN
    assign illegal = !home && en && prev_vld_q && ((filt_q ^ prev_q) == 2'b11);
`endif
endmodule

module angle_feedback_decoder #(
    parameter int          FILT_LEN = 4,
    parameter logic [15:0] POS_MIN  = 16'd0,
    parameter logic [15:0] POS_MAX  = 16'hFFFF,
    parameter logic [15:0] HOME_VAL = 16'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        home,
    input  logic        th_a,
    input  logic        th_b,
    input  logic        ph_a,
    input  logic        ph_b,
    output logic [15:0] theta_actual,
    output logic [15:0] phi_actual,
    output logic        theta_step,
    output logic        phi_step,
    output logic        theta_dir,
    output logic        phi_dir,
    output logic [1:0]  at_limit
`ifdef QUAD_ERR_DETECT_EN
    ,
    output logic [1:0]  err_flag,
    output logic [7:0]  err_cnt
`endif
);
    logic [1:0]       raw_a, raw_b, step, dir, lim;
    logic [1:0][15:0] pos;
`ifdef QUAD_ERR_DETECT_EN
    logic [1:0]       ill;
`endif

    assign raw_a = {ph_a, th_a};
    assign raw_b = {ph_b, th_b};

    for (genvar i = 0; i < 2; i++) begin : g_ax
        afd_axis #(
            .FILT_LEN(FILT_LEN), .POS_MIN(POS_MIN), .POS_MAX(POS_MAX), .HOME_VAL(HOME_VAL)
        ) u_ax (
            .clk(clk), .rst(rst), .en(en), .home(home),
            .a(raw_a[i]), .b(raw_b[i]),
            .pos(pos[i]), .step(step[i]), .dir(dir[i]), .at_lim(lim[i])
`ifdef QUAD_ERR_DETECT_EN
            , .illegal(ill[i])
`endif
        );
    end

    assign theta_actual = pos[0];
    assign phi_actual   = pos[1];
    assign theta_step   = step[0];
    assign phi_step     = step[1];
    assign theta_dir    = dir[0];
    assign phi_dir      = dir[1];
    assign at_limit     = lim;

`ifdef QUAD_ERR_DETECT_EN
    logic [1:0] err_flag_q, err_flag_d;
    logic [7:0] err_cnt_q, err_cnt_d;
    logic [8:0] err_sum;

    always_comb begin
        err_sum    = {1'b0, err_cnt_q} + 9'(ill[0]) + 9'(ill[1]);
        err_flag_d = err_flag_q | ill;
        err_cnt_d  = (err_sum > 9'd255) ? 8'hFF : err_sum[7:0];
        if (home) begin
            err_flag_d = 2'b00;
            err_cnt_d  = 8'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_flag_q <= 2'b00;
            err_cnt_q  <= 8'd0;
        end else begin
            err_flag_q <= err_flag_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign err_flag = err_flag_q;
    assign err_cnt  = err_cnt_q;
`endif
endmodule

// File: tb/tb_angle_feedback_decoder.sv
// Directed bench for angle_feedback_decoder with narrow clamp window 90..105, home 100, FILT_LEN 4.
module tb_angle_feedback_decoder;
    localparam int          FL   = 4;
    localparam logic [15:0] PMIN = 16'd90;
    localparam logic [15:0] PMAX = 16'd105;
    localparam logic [15:0] HV   = 16'd100;

    logic        clk = 1'b0;
    logic        rst, en, home, th_a, th_b, ph_a, ph_b;
    logic [15:0] theta_actual, phi_actual;
    logic        theta_step, phi_step, theta_dir, phi_dir;
    logic [1:0]  at_limit;
`ifdef QUAD_ERR_DETECT_EN
    logic [1:0]  err_flag;
    logic [7:0]  err_cnt;
`endif

    always #5 clk = ~clk;

    angle_feedback_decoder #(.FILT_LEN(FL), .POS_MIN(PMIN), .POS_MAX(PMAX), .HOME_VAL(HV)) dut (
        .clk(clk), .rst(rst), .en(en), .home(home),
        .th_a(th_a), .th_b(th_b), .ph_a(ph_a), .ph_b(ph_b),
        .theta_actual(theta_actual), .phi_actual(phi_actual),
        .theta_step(theta_step), .phi_step(phi_step),
        .theta_dir(theta_dir), .phi_dir(phi_dir), .at_limit(at_limit)
`ifdef QUAD_ERR_DETECT_EN
        , .err_flag(err_flag), .err_cnt(err_cnt)
`endif
    );

    int n_cmp = 0, n_bad = 0;
    int th_steps = 0, ph_steps = 0;
    int base, pbase;
    logic [1:0] th_s = 2'b00, ph_s = 2'b00;

    always @(posedge clk) begin
        if (theta_step) th_steps++;
        if (phi_step)   ph_steps++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] nxt(input logic up, input logic [1:0] s);
        if (up) case (s) 2'b00: return 2'b10; 2'b10: return 2'b11; 2'b11: return 2'b01; default: return 2'b00; endcase
        else    case (s) 2'b00: return 2'b01; 2'b01: return 2'b11; 2'b11: return 2'b10; default: return 2'b00; endcase
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_th(input logic [1:0] s);
        th_s = s;
        {th_a, th_b} = s;
    endtask

    // New level sampled at the 1st edge; count must appear at the 7th, not the 6th.
    task automatic th_step(input logic up, input logic [15:0] exp_pos);
        set_th(nxt(up, th_s));
        tick(FL + 2);
        chk("th_early", theta_step, 0);
        tick(1);
        chk("th_step", theta_step, 1);
        chk("th_pos", theta_actual, exp_pos);
        chk("th_dir", theta_dir, up);
        tick(3);
    endtask

    task automatic th_move(input logic up);
        set_th(nxt(up, th_s));
        tick(10);
    endtask

    initial begin
        rst = 1; en = 1; home = 0; th_a = 0; th_b = 0; ph_a = 0; ph_b = 0;
        tick(2);
        chk("rst_theta", theta_actual, HV);
        chk("rst_phi", phi_actual, HV);
        chk("rst_step", {phi_step, theta_step}, 0);
        chk("rst_lim", at_limit, 0);
        rst = 0;
        tick(10);
        chk("post_rst_theta", theta_actual, HV);
        chk("post_rst_steps", th_steps + ph_steps, 0);

        // forward x4 sequence
        th_step(1, 101); th_step(1, 102); th_step(1, 103); th_step(1, 104);

        // short glitch is rejected by the filter
        base = th_steps;
        th_a = ~th_a; tick(2); th_a = ~th_a; tick(12);
        chk("glitch_pos", theta_actual, 104);
        chk("glitch_steps", th_steps - base, 0);

        // reverse back to start
        th_step(0, 103); th_step(0, 102); th_step(0, 101); th_step(0, 100);

        // clamp at POS_MAX
        th_step(1, 101); th_step(1, 102); th_step(1, 103); th_step(1, 104);
        base = th_steps;
        th_step(1, 105); th_move(1); th_move(1);
        chk("max_pos", theta_actual, PMAX);
        chk("max_steps", th_steps - base, 1);
        chk("max_lim", at_limit, 2'b01);
        chk("max_dir", theta_dir, 1);

        home = 1; tick(1); home = 0;
        chk("home_pos", theta_actual, HV);
        chk("home_lim", at_limit, 0);

        // clamp at POS_MIN
        for (int i = 1; i <= 9; i++) th_step(0, 16'(100 - i));
        base = th_steps;
        th_step(0, 90); th_move(0); th_move(0);
        chk("min_pos", theta_actual, PMIN);
        chk("min_steps", th_steps - base, 1);
        chk("min_lim", at_limit, 2'b01);
        chk("min_dir", theta_dir, 0);

        // disabled counting, then clean re-enable
        base = th_steps;
        en = 0; th_move(1); th_move(1); en = 1; tick(10);
        chk("en0_pos", theta_actual, PMIN);
        chk("en0_steps", th_steps - base, 0);
        th_step(1, 91);

        // home wins over a coincident filtered step
        base = th_steps;
        set_th(nxt(1, th_s)); tick(FL + 2); home = 1; tick(1); home = 0;
        chk("home_co_pos", theta_actual, HV);
        chk("home_co_step", theta_step, 0);
        tick(5);
        chk("home_co_steps", th_steps - base, 0);
        chk("phi_idle_steps", ph_steps, 0);
        chk("phi_idle_pos", phi_actual, HV);

        // both axes step in the same cycle
        base = th_steps; pbase = ph_steps;
        set_th(nxt(1, th_s)); ph_s = nxt(1, ph_s); {ph_a, ph_b} = ph_s;
        tick(FL + 3);
        chk("dual_step", {phi_step, theta_step}, 2'b11);
        chk("dual_theta", theta_actual, 101);
        chk("dual_phi", phi_actual, 101);
        chk("dual_phi_dir", phi_dir, 1);
        tick(3);
        chk("dual_counts", (th_steps - base) + (ph_steps - pbase), 2);

`ifdef QUAD_ERR_DETECT_EN
        pbase = ph_steps;
        ph_s = ph_s ^ 2'b11; {ph_a, ph_b} = ph_s;
        tick(12);
        chk("ill_phi_pos", phi_actual, 101);
        chk("ill_phi_steps", ph_steps - pbase, 0);
        chk("ill_flag", err_flag, 2'b10);
        chk("ill_cnt", err_cnt, 1);
        home = 1; tick(1); home = 0;
        chk("ill_flag_clr", err_flag, 0);
        chk("ill_cnt_clr", err_cnt, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
